// File: rtl/fifo16ch_wide.sv
// fifo16ch_wide: L1A-triggered capture of 6 x 16-channel 12-bit ADC groups
// into a 128-deep sample FIFO, with an 8-deep event-record FIFO.
// Ports:
//   CLK40, RST, RST_RESYNC, FIFO_RST : clock and the three reset flavours
//   L1A, L1A_MATCH                   : trigger strobes (counted; match captures)
//   G1IN..G6IN                       : ADC groups, channel n at [12n+11:12n]
//   SAMP_MAX                         : samples per event minus one
//   RD_ENA, L1A_RD_EN                : data group advance / event record pop
//   TRIG_IN, TRIG_OUT                : one-cycle trigger pass-through
//   RDY, L1A_SMP_OUT                 : event FIFO non-empty / head record
//   DOUT_16CH                        : selected group of head sample
//   L1A_CNT, L1A_MTCH_CNT            : wrapping trigger counters
//   fmt, LA_CNTRL                    : status word and debug bus
module fifo16ch_wide (
   input  logic          CLK40,
   input  logic          RST,
   input  logic          RST_RESYNC,
   input  logic          FIFO_RST,
   input  logic          L1A,
   input  logic          L1A_MATCH,
   input  logic [191:0]  G1IN,
   input  logic [191:0]  G2IN,
   input  logic [191:0]  G3IN,
   input  logic [191:0]  G4IN,
   input  logic [191:0]  G5IN,
   input  logic [191:0]  G6IN,
   input  logic [15:0]   RD_ENA,
   input  logic          L1A_RD_EN,
   input  logic [6:0]    SAMP_MAX,
   input  logic          TRIG_IN,
   output logic          TRIG_OUT,
   output logic          RDY,
   output logic [43:0]   L1A_SMP_OUT,
   output logic [191:0]  DOUT_16CH,
   output logic [23:0]   L1A_CNT,
   output logic [11:0]   L1A_MTCH_CNT,
   output logic [15:0]   fmt,
   output logic [35:0]   LA_CNTRL
);

   typedef enum logic {IDLE, CAPTURE} cap_state_t;

   cap_state_t     state, state_nx;

   logic [1151:0]  mem [0:127];
   logic [1151:0]  head;
   logic [6:0]     wr_ptr, rd_ptr;
   logic [7:0]     data_count;

   logic [43:0]    evt_mem [0:7];
   logic [2:0]     evt_wr, evt_rd;
   logic [3:0]     evt_count;

   logic [2:0]     grp;
   logic [6:0]     sample_idx, idx_nx;
   logic [6:0]     n_m1, nm1_nx;
   logic [43:0]    rec, rec_nx;

   logic [23:0]    cnt_nx;
   logic [11:0]    mcnt_nx;
   logic [7:0]     need, free;

   logic           hold;
   logic           data_empty, data_full, evt_empty, evt_full;
   logic           wr_req, push_req;
   logic           wr_go, push_go;
   logic           adv, data_pop, evt_pop;

   // FIFO-side resets override every other same-cycle request
   assign hold       = RST | FIFO_RST;

   assign data_empty = (data_count == 8'd0);
   assign data_full  = (data_count == 8'd128);
   assign evt_empty  = (evt_count == 4'd0);
   assign evt_full   = (evt_count == 4'd8);

   assign need       = {1'b0, SAMP_MAX} + 8'd1;
   assign free       = 8'd128 - data_count;

   // Records carry the counter values as they stand after this cycle
   assign cnt_nx  = RST_RESYNC ? 24'd0 : L1A_CNT + {23'd0, L1A};
   assign mcnt_nx = RST_RESYNC ? 12'd0 : L1A_MTCH_CNT + {11'd0, L1A_MATCH};

   always_comb begin
      state_nx = state;
      wr_req   = 1'b0;
      push_req = 1'b0;
      idx_nx   = sample_idx;
      nm1_nx   = n_m1;
      rec_nx   = rec;
      unique case (state)
         IDLE: begin
            if (L1A_MATCH && !evt_full && (free >= need)) begin
               wr_req = 1'b1;
               nm1_nx = SAMP_MAX;
               rec_nx = {cnt_nx, mcnt_nx, 1'b0, SAMP_MAX};
               // a one-sample event completes in its accepting cycle
               if (SAMP_MAX == 7'd0) begin
                  push_req = 1'b1;
               end else begin
                  state_nx = CAPTURE;
                  idx_nx   = 7'd1;
               end
            end
         end
         CAPTURE: begin
            wr_req = 1'b1;
            if (sample_idx == n_m1) begin
               push_req = 1'b1;
               state_nx = IDLE;
               idx_nx   = 7'd0;
            end else begin
               idx_nx = sample_idx + 7'd1;
            end
         end
      endcase
   end

   assign wr_go    = wr_req & ~hold;
   assign push_go  = push_req & ~hold;
   assign adv      = (|RD_ENA) & ~data_empty & ~hold;
   assign data_pop = adv & (grp == 3'd6);
   assign evt_pop  = L1A_RD_EN & ~evt_empty & ~hold;

   always_ff @(posedge CLK40) begin
      if (hold) begin
         state      <= IDLE;
         sample_idx <= 7'd0;
         n_m1       <= 7'd0;
         rec        <= 44'd0;
      end else begin
         state      <= state_nx;
         sample_idx <= idx_nx;
         n_m1       <= nm1_nx;
         rec        <= rec_nx;
      end
   end

   always_ff @(posedge CLK40) begin
      if (RST) begin
         L1A_CNT      <= 24'd0;
         L1A_MTCH_CNT <= 12'd0;
         TRIG_OUT     <= 1'b0;
      end else begin
         L1A_CNT      <= cnt_nx;
         L1A_MTCH_CNT <= mcnt_nx;
         TRIG_OUT     <= TRIG_IN;
      end
   end

   always_ff @(posedge CLK40) begin
      if (wr_go) begin
         mem[wr_ptr] <= {G6IN, G5IN, G4IN, G3IN, G2IN, G1IN};
      end
   end

   always_ff @(posedge CLK40) begin
      if (push_go) begin
         evt_mem[evt_wr] <= rec_nx;
      end
   end

   always_ff @(posedge CLK40) begin
      if (hold) begin
         wr_ptr     <= 7'd0;
         rd_ptr     <= 7'd0;
         data_count <= 8'd0;
         grp        <= 3'd1;
      end else begin
         if (wr_go) wr_ptr <= wr_ptr + 7'd1;
         if (data_pop) rd_ptr <= rd_ptr + 7'd1;
         unique case ({wr_go, data_pop})
            2'b10:   data_count <= data_count + 8'd1;
            2'b01:   data_count <= data_count - 8'd1;
            default: data_count <= data_count;
         endcase
         if (adv) grp <= (grp == 3'd6) ? 3'd1 : grp + 3'd1;
      end
   end

   always_ff @(posedge CLK40) begin
      if (hold) begin
         evt_wr    <= 3'd0;
         evt_rd    <= 3'd0;
         evt_count <= 4'd0;
      end else begin
         if (push_go) evt_wr <= evt_wr + 3'd1;
         if (evt_pop) evt_rd <= evt_rd + 3'd1;
         unique case ({push_go, evt_pop})
            2'b10:   evt_count <= evt_count + 4'd1;
            2'b01:   evt_count <= evt_count - 4'd1;
            default: evt_count <= evt_count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      DOUT_16CH = '0;
      if (!data_empty) begin
         case (grp)
            3'd1:    DOUT_16CH = head[191:0];
            3'd2:    DOUT_16CH = head[383:192];
            3'd3:    DOUT_16CH = head[575:384];
            3'd4:    DOUT_16CH = head[767:576];
            3'd5:    DOUT_16CH = head[959:768];
            3'd6:    DOUT_16CH = head[1151:960];
            default: DOUT_16CH = '0;
         endcase
      end
   end

   assign RDY         = ~evt_empty;
   assign L1A_SMP_OUT = evt_empty ? 44'd0 : evt_mem[evt_rd];

   assign fmt = {data_full, data_empty, evt_full, evt_empty,
                 1'b0, grp, data_count};

   assign LA_CNTRL = {(state == CAPTURE), sample_idx, grp, RDY,
                      wr_ptr, rd_ptr, evt_count, 6'd0};

endmodule

// File: tb/tb_fifo16ch_wide.sv
// tb_fifo16ch_wide: directed and random stimulus against a queue-based
// model of fifo16ch_wide; expected reads are queued and checked by a monitor.
module tb_fifo16ch_wide;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          rst_resync = 1'b0;
   logic          fifo_rst = 1'b0;
   logic          l1a = 1'b0;
   logic          l1a_match = 1'b0;
   logic          l1a_rd_en = 1'b0;
   logic          trig_in = 1'b0;
   logic [15:0]   rd_ena = 16'd0;
   logic [6:0]    samp_max = 7'd0;
   logic [191:0]  g [6];

   logic          TRIG_OUT, RDY;
   logic [43:0]   L1A_SMP_OUT;
   logic [191:0]  DOUT_16CH;
   logic [23:0]   L1A_CNT;
   logic [11:0]   L1A_MTCH_CNT;
   logic [15:0]   fmt;
   logic [35:0]   LA_CNTRL;

   fifo16ch_wide dut (
      .CLK40(clk), .RST(rst), .RST_RESYNC(rst_resync),
      .FIFO_RST(fifo_rst), .L1A(l1a), .L1A_MATCH(l1a_match),
      .G1IN(g[0]), .G2IN(g[1]), .G3IN(g[2]),
      .G4IN(g[3]), .G5IN(g[4]), .G6IN(g[5]),
      .RD_ENA(rd_ena), .L1A_RD_EN(l1a_rd_en), .SAMP_MAX(samp_max),
      .TRIG_IN(trig_in), .TRIG_OUT(TRIG_OUT), .RDY(RDY),
      .L1A_SMP_OUT(L1A_SMP_OUT), .DOUT_16CH(DOUT_16CH),
      .L1A_CNT(L1A_CNT), .L1A_MTCH_CNT(L1A_MTCH_CNT),
      .fmt(fmt), .LA_CNTRL(LA_CNTRL)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [1151:0] m_dq [$];
   logic [43:0]   m_eq [$];
   int            m_grp = 1;
   int            m_left = 0;
   logic [43:0]   m_rec = '0;
   logic [23:0]   m_cnt = '0;
   logic [11:0]   m_mcnt = '0;
   logic          m_trig = 1'b0;

   logic [191:0]  exp_dout [$];
   logic [43:0]   exp_evt [$];
   bit            pat_mode = 1'b0;

   task automatic chk(input string nm, input logic [191:0] act,
                      input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [191:0] m_dout();
      logic [1151:0] s;
      if (m_dq.size() == 0) return '0;
      s = m_dq[0];
      return s[192*(m_grp-1) +: 192];
   endfunction

   function automatic logic [43:0] m_evt();
      if (m_eq.size() == 0) return '0;
      return m_eq[0];
   endfunction

   function automatic logic [15:0] m_fmt();
      return {m_dq.size() == 128, m_dq.size() == 0,
              m_eq.size() == 8, m_eq.size() == 0,
              1'b0, 3'(m_grp), 8'(m_dq.size())};
   endfunction

   // Behaviour of one clock edge, from occupancy before the edge
   task automatic model_step();
      int ds, es, n;
      logic [23:0] c;
      logic [11:0] mc;
      logic [1151:0] smp;
      smp = {g[5], g[4], g[3], g[2], g[1], g[0]};
      ds = m_dq.size();
      es = m_eq.size();
      if (rst) begin
         m_dq.delete(); m_eq.delete();
         m_grp = 1; m_left = 0;
         m_cnt = '0; m_mcnt = '0; m_trig = 1'b0;
      end else begin
         m_trig = trig_in;
         c  = rst_resync ? 24'd0 : m_cnt + 24'(l1a);
         mc = rst_resync ? 12'd0 : m_mcnt + 12'(l1a_match);
         m_cnt = c;
         m_mcnt = mc;
         if (fifo_rst) begin
            m_dq.delete(); m_eq.delete();
            m_grp = 1; m_left = 0;
         end else begin
            if (rd_ena != 0 && ds > 0) begin
               if (m_grp == 6) begin
                  void'(m_dq.pop_front());
                  m_grp = 1;
               end else begin
                  m_grp++;
               end
            end
            if (l1a_rd_en && es > 0) void'(m_eq.pop_front());
            n = int'(samp_max) + 1;
            if (m_left > 0) begin
               m_dq.push_back(smp);
               m_left--;
               if (m_left == 0) m_eq.push_back(m_rec);
            end else if (l1a_match && (128 - ds) >= n && es < 8) begin
               m_dq.push_back(smp);
               m_rec = {c, mc, 1'b0, samp_max};
               m_left = n - 1;
               if (m_left == 0) m_eq.push_back(m_rec);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("dout", DOUT_16CH, m_dout());
      chk("fmt", 192'(fmt), 192'(m_fmt()));
      chk("l1a_cnt", 192'(L1A_CNT), 192'(m_cnt));
      chk("mtch_cnt", 192'(L1A_MTCH_CNT), 192'(m_mcnt));
      chk("rdy", 192'(RDY), 192'(m_eq.size() > 0));
      chk("smp_out", 192'(L1A_SMP_OUT), 192'(m_evt()));
      chk("trig_out", 192'(TRIG_OUT), 192'(m_trig));
      chk("la", 192'({LA_CNTRL[35], LA_CNTRL[27:24], LA_CNTRL[9:0]}),
          192'({m_left > 0, 3'(m_grp), m_eq.size() > 0,
                4'(m_eq.size()), 6'd0}));
      if (rd_ena != 0) begin
         if (exp_dout.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_queue: got empty want entry");
         end else begin
            chk("rd_dout", DOUT_16CH, exp_dout.pop_front());
         end
      end
      if (l1a_rd_en) begin
         if (exp_evt.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL evt_queue: got empty want entry");
         end else begin
            chk("evt_rec", 192'(L1A_SMP_OUT), 192'(exp_evt.pop_front()));
         end
      end
   end

   task automatic rand_g();
      for (int i = 0; i < 6; i++)
         g[i] = {$urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom()};
   endtask

   task automatic tick();
      if (rd_ena != 0) exp_dout.push_back(m_dout());
      if (l1a_rd_en) exp_evt.push_back(m_evt());
      @(posedge clk);
      #1;
      rst = 1'b0; rst_resync = 1'b0; fifo_rst = 1'b0;
      l1a = 1'b0; l1a_match = 1'b0; l1a_rd_en = 1'b0;
      trig_in = 1'b0; rd_ena = 16'd0;
      if (!pat_mode) rand_g();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   int ec [3] = '{1, 3, 4};
   logic [23:0] c0;
   logic [11:0] mc0;
   logic [11:0] want;

   initial begin
      rand_g();
      rst = 1'b1; tick();
      rst = 1'b1; tick();

      chk("rst_fmt", 192'(fmt), 192'(16'h5100));
      chk("rst_dout", DOUT_16CH, '0);
      chk("rst_rdy", 192'(RDY), 192'(0));
      chk("rst_smp", 192'(L1A_SMP_OUT), 192'(0));
      chk("rst_trig", 192'(TRIG_OUT), 192'(0));
      chk("rst_cnt", 192'(L1A_CNT), 192'(0));
      chk("rst_la", 192'(LA_CNTRL),
          192'({1'b0, 7'd0, 3'd1, 1'b0, 7'd0, 7'd0, 4'd0, 6'd0}));

      // matches at t0, t0+6, t0+12, t0+22 with N = 8
      samp_max = 7'd7;
      for (int t = 0; t < 23; t++) begin
         if (t == 0 || t == 6 || t == 12 || t == 22) begin
            l1a = 1'b1; l1a_match = 1'b1;
         end
         tick();
      end
      idle(10);
      chk("seq_cnt", 192'(L1A_CNT), 192'(4));
      chk("seq_mcnt", 192'(L1A_MTCH_CNT), 192'(4));
      chk("seq_dcount", 192'(fmt[7:0]), 192'(24));
      chk("seq_evcnt", 192'(LA_CNTRL[9:6]), 192'(3));
      for (int k = 0; k < 3; k++) begin
         chk("seq_rec_cnt", 192'(L1A_SMP_OUT[43:20]), 192'(ec[k]));
         chk("seq_rec_mcnt", 192'(L1A_SMP_OUT[19:8]), 192'(ec[k]));
         chk("seq_rec_n", 192'(L1A_SMP_OUT[7:0]), 192'(7));
         l1a_rd_en = 1'b1;
         tick();
      end
      chk("seq_rdy0", 192'(RDY), 192'(0));

      // patterned event, then 48 group advances
      fifo_rst = 1'b1; tick();
      pat_mode = 1'b1;
      samp_max = 7'd7;
      for (int s = 0; s < 8; s++) begin
         for (int gi = 0; gi < 6; gi++)
            for (int n = 0; n < 16; n++)
               g[gi][12*n +: 12] = {4'(n), 4'(s), 4'(gi + 1)};
         if (s == 0) l1a_match = 1'b1;
         tick();
      end
      pat_mode = 1'b0;
      rand_g();
      for (int k = 0; k < 48; k++) begin
         want = {4'd0, 4'(k / 6), 4'(k % 6 + 1)};
         chk("pat_ch0", 192'(DOUT_16CH[11:0]), 192'(want));
         want = {4'hF, 4'(k / 6), 4'(k % 6 + 1)};
         chk("pat_ch15", 192'(DOUT_16CH[191:180]), 192'(want));
         rd_ena = 16'(1 << (k % 16));
         tick();
      end
      chk("pat_empty", 192'(fmt[14]), 192'(1));
      chk("pat_dout0", DOUT_16CH, '0);

      // free-space boundary
      fifo_rst = 1'b1; tick();
      samp_max = 7'd120; l1a_match = 1'b1; tick();
      idle(122);
      chk("fill_121", 192'(fmt[7:0]), 192'(121));
      samp_max = 7'd7; l1a_match = 1'b1; tick();
      idle(3);
      chk("fill_drop", 192'(fmt[7:0]), 192'(121));
      chk("fill_drop_ev", 192'(LA_CNTRL[9:6]), 192'(1));
      for (int k = 0; k < 6; k++) begin
         rd_ena = 16'h8000; tick();
      end
      chk("fill_120", 192'(fmt[7:0]), 192'(120));
      l1a_match = 1'b1; tick();
      idle(8);
      chk("fill_128", 192'(fmt[7:0]), 192'(8'h80));
      chk("fill_full", 192'(fmt[15]), 192'(1));
      chk("fill_ev2", 192'(LA_CNTRL[9:6]), 192'(2));

      // FIFO_RST mid-capture
      fifo_rst = 1'b1; tick();
      c0 = L1A_CNT; mc0 = L1A_MTCH_CNT;
      samp_max = 7'd7; l1a = 1'b1; l1a_match = 1'b1; tick();
      tick(); tick();
      fifo_rst = 1'b1; tick();
      idle(10);
      chk("abort_rdy", 192'(RDY), 192'(0));
      chk("abort_dc", 192'(fmt[7:0]), 192'(0));
      chk("abort_cnt", 192'(L1A_CNT), 192'(c0 + 24'd1));
      chk("abort_mcnt", 192'(L1A_MTCH_CNT), 192'(mc0 + 12'd1));

      // event FIFO full with single-sample events
      samp_max = 7'd0;
      for (int i = 0; i < 9; i++) begin
         l1a = 1'b1; l1a_match = 1'b1; tick();
         tick();
      end
      chk("evf_full", 192'(fmt[13]), 192'(1));
      chk("evf_cnt", 192'(LA_CNTRL[9:6]), 192'(8));
      chk("evf_dc", 192'(fmt[7:0]), 192'(8));
      for (int i = 0; i < 8; i++) begin
         l1a_rd_en = 1'b1; tick();
      end
      chk("evf_rdy0", 192'(RDY), 192'(0));
      chk("evf_empty", 192'(fmt[12]), 192'(1));

      // trigger pass-through
      trig_in = 1'b1;
      chk("trig_pre", 192'(TRIG_OUT), 192'(0));
      tick();
      chk("trig_hi", 192'(TRIG_OUT), 192'(1));
      tick();
      chk("trig_lo", 192'(TRIG_OUT), 192'(0));

      // resync wins over same-cycle strobes
      l1a = 1'b1; l1a_match = 1'b1; rst_resync = 1'b1; tick();
      chk("resync_cnt", 192'(L1A_CNT), 192'(0));
      chk("resync_mcnt", 192'(L1A_MTCH_CNT), 192'(0));

      fifo_rst = 1'b1; tick();
      for (int i = 0; i < 4000; i++) begin
         l1a       = ($urandom_range(3) == 0);
         l1a_match = ($urandom_range(5) == 0);
         if ($urandom_range(49) == 0)
            samp_max = ($urandom_range(9) == 0) ?
                       7'($urandom_range(127)) : 7'($urandom_range(20));
         rd_ena    = ($urandom_range(1) == 0) ?
                     16'($urandom_range(65535, 1)) : 16'd0;
         l1a_rd_en = ($urandom_range(7) == 0);
         fifo_rst  = ($urandom_range(599) == 0);
         rst_resync = ($urandom_range(399) == 0);
         trig_in   = 1'($urandom_range(1));
         rst       = (i == 2000);
         tick();
      end
      tick();
      chk("rdq_drain", 192'(exp_dout.size()), 192'(0));
      chk("evq_drain", 192'(exp_evt.size()), 192'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
